// File: rtl/slice_pkg.sv
// slice_pkg: state encoding, space-to-depth group offsets and frame beat count
// shared by the slice_ctrl sequencer.
package slice_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // group g selects the (dy, dx) pixel inside each 2x2 input block
    localparam int unsigned DY [4] = '{0, 1, 0, 1};
    localparam int unsigned DX [4] = '{0, 0, 1, 1};

    function automatic int unsigned beat_count(input int unsigned w, input int unsigned h,
                                               input int unsigned k);
        return (w / 2) * (h / 2) * 4 * k;
    endfunction

endpackage

// File: rtl/slice_ctrl_skid.sv
// slice_ctrl_skid: two-entry in-order buffer between BRAM read data and the output stream.
// The producer never pushes into a full buffer; occ_o lets it throttle its reads.
module slice_ctrl_skid #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            occ_o
);
    logic [DATA_WIDTH-1:0] head_q, tail_q;
    logic [1:0]            occ_q;
    logic                  pop;

    assign pop         = out_ready_i && (occ_q != 2'd0);
    assign out_valid_o = occ_q != 2'd0;
    assign out_data_o  = head_q;
    assign occ_o       = occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            occ_q <= occ_q + {1'b0, in_valid_i} - {1'b0, pop};
            if (pop && occ_q == 2'd2)
                head_q <= tail_q;
            else if (in_valid_i && (occ_q == 2'd0 || (occ_q == 2'd1 && pop)))
                head_q <= in_data_i;
            if (in_valid_i && ((occ_q == 2'd1 && !pop) || (occ_q == 2'd2 && pop)))
                tail_q <= in_data_i;
        end
    end

endmodule

// File: rtl/slice_ctrl.sv
// slice_ctrl: streams a W x H x K map from BRAM as its (W/2) x (H/2) x 4K space-to-depth slice.
// Defining SLICE_CTRL_PERF_EN adds a saturating stall_cnt output.
module slice_ctrl
    import slice_pkg::*;
#(
    parameter int W          = 4,
    parameter int H          = 4,
    parameter int K          = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(W * H * K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef SLICE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);
    localparam int CW = $clog2(K + 1);
    localparam int XW = $clog2(W / 2 + 1);
    localparam int YW = $clog2(H / 2 + 1);
    localparam logic [ADDR_WIDTH-1:0] WA  = ADDR_WIDTH'(W);
    localparam logic [ADDR_WIDTH-1:0] KA  = ADDR_WIDTH'(K);
    localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

    state_t        state_q;
    logic [CW-1:0] c_q;
    logic [1:0]    g_q;
    logic [XW-1:0] ox_q;
    logic [YW-1:0] oy_q;
    logic          rd_inflight_q;
    logic [1:0]    occ;
    logic          issue, pop, c_last, ox_last, oy_last, last_rd;

    assign c_last  = c_q == CW'(K - 1);
    assign ox_last = ox_q == XW'(W / 2 - 1);
    assign oy_last = oy_q == YW'(H / 2 - 1);
    assign last_rd = c_last && g_q == 2'd3 && ox_last && oy_last;
    assign pop     = out_valid && out_ready;
    // a pop this cycle frees the slot the in-flight read will land in, keeping 1 beat/cycle
    assign issue   = state_q == RUN && (occ == 2'd0 || (occ == 2'd1 && (!rd_inflight_q || pop)));

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign mem_rd_en = issue;
    assign mem_addr  = ((ADDR_WIDTH'(oy_q) * TWO + ADDR_WIDTH'(DY[g_q])) * WA
                        + ADDR_WIDTH'(ox_q) * TWO + ADDR_WIDTH'(DX[g_q])) * KA + ADDR_WIDTH'(c_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            c_q           <= '0;
            g_q           <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            rd_inflight_q <= issue;
            if (issue) begin
                c_q <= c_last ? '0 : c_q + 1'b1;
                if (c_last) begin
                    g_q <= g_q + 2'd1;
                    if (g_q == 2'd3) begin
                        ox_q <= ox_last ? '0 : ox_q + 1'b1;
                        if (ox_last)
                            oy_q <= oy_last ? '0 : oy_q + 1'b1;
                    end
                end
            end
            case (state_q)
                IDLE:    if (start) state_q <= RUN;
                RUN:     if (issue && last_rd) state_q <= DRAIN;
                DRAIN:   if (!rd_inflight_q && (occ == 2'd0 || (occ == 2'd1 && pop))) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    slice_ctrl_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rd_inflight_q),
        .in_data_i   (mem_rdata),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .occ_o       (occ)
    );

`ifdef SLICE_CTRL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start))
            stall_q <= '0;
        else if (busy && out_valid && !out_ready && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_slice_ctrl.sv
// tb_slice_ctrl: randomized scoreboard bench for slice_ctrl (W=4, H=4, K=3), BRAM holds mem[a]=a.
`timescale 1ns/1ps
module tb_slice_ctrl;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int DW = 16;
    localparam int AW = $clog2(W * H * K);
    localparam int N  = (W / 2) * (H / 2) * 4 * K;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic          busy, done, mem_rd_en, out_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0, out_data, prev_data = '0;
`ifdef SLICE_CTRL_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    int n_checks = 0, n_err = 0, cyc = 0, e;
    int exp_q[$];
    int frame_beats = 0, frame_rds = 0, rd_cnt = 0, beat_cnt = 0, done_cnt = 0;
    int last_beat_cyc = -10, first_beat_cyc = -1, start_cyc = 0;
    bit stall_prev = 0, busy_chk = 0, auto_ready = 1, rand_ready = 0;

    slice_ctrl #(.W(W), .H(H), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SLICE_CTRL_PERF_EN
        , .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= DW'(mem_addr);

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // expected stream: beat n -> (oy, ox, g, c), value = element address of input pixel
    function automatic void push_frame();
        for (int n = 0; n < N; n++) begin
            int c  = n % K;
            int g  = (n / K) % 4;
            int ox = (n / (4 * K)) % (W / 2);
            int oy = n / (4 * K * (W / 2));
            int y  = 2 * oy + (g % 2);
            int x  = 2 * ox + g / 2;
            exp_q.push_back((y * W + x) * K + c);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        push_frame();
        start_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < budget) begin
            tick();
            t++;
        end
        chk(done_cnt != d0, name, t, budget);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (auto_ready) out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0; busy_chk = 0; frame_beats = 0; frame_rds = 0; rd_cnt = 0; beat_cnt = 0;
        end else begin
            if (stall_prev)
                chk(out_valid && out_data == prev_data, "stall_hold", out_data, prev_data);
            if (mem_rd_en) begin
                chk(rd_cnt - beat_cnt + 1 - int'(out_valid && out_ready) <= 2, "rd_overrun",
                    rd_cnt - beat_cnt, 1);
                rd_cnt++;
                frame_rds++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk(1'b0, "extra_beat", out_data, -1);
                else begin
                    e = exp_q.pop_front();
                    chk(out_data == DW'(e), "beat_data", out_data, e);
                end
                if (frame_beats == 0) first_beat_cyc = cyc;
                frame_beats++;
                beat_cnt++;
                last_beat_cyc = cyc;
            end
            if (done) begin
                chk(exp_q.size() == 0 && frame_beats == N, "done_frame", frame_beats, N);
                chk(cyc == last_beat_cyc + 1, "done_timing", cyc - last_beat_cyc, 1);
                done_cnt++;
                busy_chk = 1;
                frame_beats = 0;
                frame_rds = 0;
            end else if (busy_chk) begin
                chk(!busy, "busy_after_done", busy, 0);
                busy_chk = 0;
            end
            stall_prev = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        int t, dc;
        repeat (3) tick();
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(mem_rd_en == 1'b0, "rst_rd_en", mem_rd_en, 0);
        chk(mem_addr == '0, "rst_addr", mem_addr, 0);
        chk(out_valid == 1'b0, "rst_valid", out_valid, 0);
        chk(out_data == '0, "rst_data", out_data, 0);
`ifdef SLICE_CTRL_PERF_EN
        chk(stall_cnt == 32'd0, "rst_stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b0;
        tick();

        // full-rate frame, then a back-to-back frame started the cycle after done
        start_frame();
        wait_done(300, "t1_done_timeout");
        chk(last_beat_cyc - first_beat_cyc == N - 1, "t1_throughput", last_beat_cyc - first_beat_cyc, N - 1);
        chk(first_beat_cyc - start_cyc >= 2, "t1_first_latency", first_beat_cyc - start_cyc, 2);
        start_frame();
        wait_done(300, "t6_done_timeout");

        // random backpressure
        rand_ready = 1;
        repeat (3) tick();
        start_frame();
        wait_done(2000, "t2_done_timeout");
        rand_ready = 0;
        repeat (3) tick();

        // start pulsed again mid-frame must be ignored
        start_frame();
        repeat (15) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        dc = done_cnt;
        wait_done(300, "t4_done_timeout");
        repeat (10) tick();
        chk(done_cnt == dc + 1, "t4_single_done", done_cnt - dc, 1);

        // reset mid-frame after 10 beats
        start_frame();
        t = 0;
        while (frame_beats < 10 && t < 100) begin
            tick();
            t++;
        end
        chk(frame_beats >= 10, "t3_beats_timeout", frame_beats, 10);
        rst = 1'b1;
        exp_q.delete();
        dc = done_cnt;
        tick();
        chk(out_valid == 1'b0, "t3_valid", out_valid, 0);
        chk(busy == 1'b0, "t3_busy", busy, 0);
        chk(mem_rd_en == 1'b0, "t3_rd_en", mem_rd_en, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk(done_cnt == dc, "t3_no_done", done_cnt - dc, 0);
        start_frame();
        wait_done(300, "t3_done_timeout");

        // output held off for 20 cycles after first valid
        auto_ready = 0;
        out_ready = 1'b0;
        tick();
        start_frame();
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(out_valid == 1'b1, "t5_valid_timeout", t, 50);
        repeat (20) @(posedge clk);
        #1;
        chk(out_valid == 1'b1, "t5_valid_held", out_valid, 1);
        chk(out_data == '0, "t5_data_held", out_data, 0);
        chk(frame_rds <= 2, "t5_reads", frame_rds, 2);
`ifdef SLICE_CTRL_PERF_EN
        chk(stall_cnt == 32'd20, "t5_stall_cnt", stall_cnt, 20);
`endif
        out_ready = 1'b1;
        auto_ready = 1;
        wait_done(300, "t5_done_timeout");
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, want finish by 300000ns");
        $fatal(1);
    end

endmodule
